// File: rtl/i2c_write_sequencer.sv
// i2c_write_sequencer
// Feeds one I2C write transaction to a byte-level I2C master. The CPU fills
// an internal FIFO with data bytes and then issues i_Go with a 7-bit target
// address. The sequencer requests a start, presents the address with
// R/nW=0, and streams one FIFO byte per data-byte ACK from the master. It
// then requests a stop and pulses o_Done once the bus is released.
//
// Ports
//   i_CLK, i_RESET        clock (rising edge) and synchronous active-high reset
//   i_ENABLE              0 freezes every register, including the FIFO
//   i_WrData, i_WrPush    FIFO push interface; pushes are accepted in any state
//   i_Address, i_Go       transaction launch; address is latched on an accepted Go
//   o_Full, o_Level       FIFO status (o_Level ranges 0..BuferSize)
//   o_Busy, o_Done        not-IDLE flag and end-of-transaction pulse
//   o_Error, o_Overflow   sticky NACK / push-while-full flags, cleared by accepted Go
//   o_Start, o_Stop       start pulse and stop request (held until i_BusIdle)
//   o_Address, o_R_NW     latched target address and direction bit (always write)
//   o_WriteData           registered FIFO head byte presented during DATA
//   i_AddrAck, i_ByteAck  master acknowledges for the address and data bytes
//   i_Nack, i_BusIdle     master NACK indication and stop-complete indication
module i2c_write_sequencer #(
  parameter int DataWidth = 8,
  parameter int BuferSize = 64
) (
  input  logic                       i_CLK,
  input  logic                       i_RESET,
  input  logic                       i_ENABLE,
  input  logic [DataWidth-1:0]       i_WrData,
  input  logic                       i_WrPush,
  input  logic [6:0]                 i_Address,
  input  logic                       i_Go,
  output logic                       o_Full,
  output logic [$clog2(BuferSize):0] o_Level,
  output logic                       o_Busy,
  output logic                       o_Done,
  output logic                       o_Error,
  output logic                       o_Overflow,
  output logic                       o_Start,
  output logic                       o_Stop,
  output logic [6:0]                 o_Address,
  output logic                       o_R_NW,
  output logic [DataWidth-1:0]       o_WriteData,
  input  logic                       i_AddrAck,
  input  logic                       i_ByteAck,
  input  logic                       i_Nack,
  input  logic                       i_BusIdle
);

  localparam int AW = $clog2(BuferSize);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(BuferSize);
  localparam logic [AW-1:0] PTR_ZERO   = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 full_q, full_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 overflow_q, overflow_d;
  logic                 start_q, start_d;
  logic                 stop_q, stop_d;
  logic [6:0]           address_q, address_d;
  logic [DataWidth-1:0] write_data_q, write_data_d;
  logic [DataWidth-1:0] mem_q [0:BuferSize-1];

  logic                 push_s;
  logic                 pop_s;
  logic                 flush_s;
  logic [DataWidth-1:0] head_s;

  // Next-state, FIFO bookkeeping and registered-output computation.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    full_d       = full_q;
    busy_d       = busy_q;
    done_d       = done_q;
    error_d      = error_q;
    overflow_d   = overflow_q;
    start_d      = start_q;
    stop_d       = stop_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    flush_s      = 1'b0;
    head_s       = write_data_q;

    if (i_ENABLE) begin
      case (state_q)
        IDLE: begin
          if (i_Go && (level_q != LEVEL_ZERO)) begin
            state_d    = START;
            address_d  = i_Address;
            error_d    = 1'b0;
            overflow_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        START: begin
          state_d = ADDR;
        end
        ADDR: begin
          if (i_Nack) begin
            error_d = 1'b1;
            flush_s = 1'b1;
            state_d = STOP;
          end else if (i_AddrAck) begin
            state_d = DATA;
          end else begin
            state_d = ADDR;
          end
        end
        DATA: begin
          if (i_Nack) begin
            error_d = 1'b1;
            flush_s = 1'b1;
            state_d = STOP;
          end else if (i_ByteAck) begin
            pop_s = 1'b1;
            // A push alongside the pop is always accepted, so the FIFO only
            // drains when the last entry leaves with no replacement arriving.
            if ((level_q == LEVEL_ONE) && !i_WrPush) begin
              state_d = STOP;
            end else begin
              state_d = DATA;
            end
          end else begin
            state_d = DATA;
          end
        end
        STOP: begin
          if (i_BusIdle) begin
            state_d = IDLE;
          end else begin
            state_d = STOP;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase

      // A pop in the same cycle frees a slot, so push-at-full is legal then.
      push_s     = i_WrPush && (!full_q || pop_s);
      overflow_d = overflow_d | (i_WrPush & ~push_s);

      wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LEVEL_ONE;
        2'b01:   level_d = level_q - LEVEL_ONE;
        default: level_d = level_q;
      endcase

      // A NACK discards every queued byte, including one pushed this cycle.
      rd_ptr_d = flush_s ? wr_ptr_d : rd_ptr_d;
      level_d  = flush_s ? LEVEL_ZERO : level_d;

      // The byte being pushed this cycle becomes the head when the FIFO is
      // otherwise empty after any pop, so forward it around the memory.
      head_s = (push_s && (wr_ptr_q == rd_ptr_d)) ? i_WrData : mem_q[rd_ptr_d];

      write_data_d = (state_d == DATA) ? head_s : write_data_q;
      full_d       = (level_d == LEVEL_FULL);
      busy_d       = (state_d != IDLE);
      start_d      = (state_d == START);
      stop_d       = (state_d == STOP);
      done_d       = (state_q == STOP) && (state_d == IDLE);
    end else begin
      push_s = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state_q      <= IDLE;
      wr_ptr_q     <= PTR_ZERO;
      rd_ptr_q     <= PTR_ZERO;
      level_q      <= LEVEL_ZERO;
      full_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      overflow_q   <= 1'b0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      address_q    <= 7'd0;
      write_data_q <= {DataWidth{1'b0}};
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      full_q       <= full_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      overflow_q   <= overflow_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge i_CLK) begin
    if (push_s && !i_RESET) begin
      mem_q[wr_ptr_q] <= i_WrData;
    end
  end

  assign o_Full      = full_q;
  assign o_Level     = level_q;
  assign o_Busy      = busy_q;
  assign o_Done      = done_q;
  assign o_Error     = error_q;
  assign o_Overflow  = overflow_q;
  assign o_Start     = start_q;
  assign o_Stop      = stop_q;
  assign o_Address   = address_q;
  assign o_R_NW      = 1'b0;
  assign o_WriteData = write_data_q;

endmodule
